// File: rtl/wt_dcache_refill_ctrl.sv
// Refill controller feeding the dcache array's cache-line write port: assembles
// memory return beats into a line, issues a one-cycle line write, and runs the flush sweep.
module wt_dcache_refill_ctrl #(
    parameter int unsigned LineWidth = 128,
    parameter int unsigned BeatWidth = 64,
    parameter int unsigned SetAssoc  = 8,
    parameter int unsigned IdxWidth  = 8,
    parameter int unsigned TagWidth  = 44,
    parameter int unsigned OffWidth  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    output logic                   flush_ack_o,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_nc_i,
    input  logic [SetAssoc-1:0]    cmd_way_i,
    input  logic [TagWidth-1:0]    cmd_tag_i,
    input  logic [IdxWidth-1:0]    cmd_idx_i,
    input  logic [OffWidth-1:0]    cmd_off_i,
    input  logic                   beat_valid_i,
    output logic                   beat_ready_o,
    input  logic [BeatWidth-1:0]   beat_data_i,
    output logic                   done_o,
    output logic                   wr_cl_vld_o,
    output logic                   wr_cl_nc_o,
    output logic [SetAssoc-1:0]    wr_cl_we_o,
    output logic [TagWidth-1:0]    wr_cl_tag_o,
    output logic [IdxWidth-1:0]    wr_cl_idx_o,
    output logic [OffWidth-1:0]    wr_cl_off_o,
    output logic [LineWidth-1:0]   wr_cl_data_o,
    output logic [LineWidth/8-1:0] wr_cl_data_be_o,
    output logic [SetAssoc-1:0]    wr_vld_bits_o
);

    localparam int unsigned NB   = LineWidth / BeatWidth;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_FLUSH} state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [IdxWidth-1:0]   r_flush_idx;
    logic [LineWidth-1:0]  r_line;
    logic                  r_nc;
    logic [SetAssoc-1:0]   r_way;
    logic [TagWidth-1:0]   r_tag;
    logic [IdxWidth-1:0]   r_idx;
    logic [OffWidth-1:0]   r_off;

    logic w_write;
    logic w_flush;
    logic w_cl_write;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_flush_idx <= '0;
            r_line      <= '0;
            r_nc        <= 1'b0;
            r_way       <= '0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_off       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Flush has priority over a command presented in the same cycle
                    if (flush_i) begin
                        r_state <= S_FLUSH;
                    end else if (cmd_valid_i) begin
                        r_nc    <= cmd_nc_i;
                        r_way   <= cmd_way_i;
                        r_tag   <= cmd_tag_i;
                        r_idx   <= cmd_idx_i;
                        r_off   <= cmd_off_i;
                        r_line  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (beat_valid_i) begin
                        for (int unsigned b = 0; b < NB; b++) begin
                            if (r_cnt == CntW'(b)) begin
                                r_line[b*BeatWidth +: BeatWidth] <= beat_data_i;
                            end
                        end
                        r_cnt <= r_cnt + CntW'(1);
                        if (r_nc || (r_cnt == CntW'(NB - 1))) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    r_flush_idx <= r_flush_idx + IdxWidth'(1);
                    if (r_flush_idx == '1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_write    = (r_state == S_WRITE);
    assign w_flush    = (r_state == S_FLUSH);
    assign w_cl_write = w_write && !r_nc;

    assign cmd_ready_o     = (r_state == S_IDLE) && !flush_i;
    assign beat_ready_o    = (r_state == S_COLLECT);
    assign done_o          = w_write;
    assign flush_ack_o     = w_flush && (r_flush_idx == '1);
    assign wr_cl_vld_o     = w_write || w_flush;
    assign wr_cl_nc_o      = w_write && r_nc;
    assign wr_cl_we_o      = w_flush ? '1 : (w_cl_write ? r_way : '0);
    assign wr_vld_bits_o   = w_cl_write ? r_way : '0;
    assign wr_cl_tag_o     = w_write ? r_tag : '0;
    assign wr_cl_idx_o     = w_flush ? r_flush_idx : (w_write ? r_idx : '0);
    assign wr_cl_off_o     = w_write ? r_off : '0;
    assign wr_cl_data_o    = w_write ? r_line : '0;
    assign wr_cl_data_be_o = w_cl_write ? '1 : '0;

    a_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cmd_valid_i && cmd_ready_o && !cmd_nc_i) |-> $onehot(cmd_way_i));

    a_no_write_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((r_state == S_IDLE) || (r_state == S_COLLECT)) |-> !wr_cl_vld_o);

endmodule

// File: doc/wt_dcache_refill_ctrl.md
Name: wt_dcache_refill_ctrl

Overview:
Upstream feeder of the dcache memory array's cache-line write port (port 0 write).
- Accepts a refill command from the miss unit and collects memory return beats into a full cache line.
- Issues one single-cycle cache-line write carrying tag, index, way-enable and valid bits.
- Also performs a full-cache invalidation sweep on flush, one set per cycle.

Parameters:
LineWidth, 128, cache-line width in bits; multiple of BeatWidth
BeatWidth, 64, memory return beat width in bits
SetAssoc, 8, number of ways
IdxWidth, 8, cache-line index width; flush sweeps 2**IdxWidth sets
TagWidth, 44, tag width
OffWidth, 4, byte offset width within a line

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  start invalidation sweep (level; sampled in IDLE)
flush_ack_o  out  1  one-cycle pulse after the last set is invalidated
cmd_valid_i  in  1  refill command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_nc_i  in  1  noncacheable: single beat, no array update
cmd_way_i  in  SetAssoc  one-hot victim way
cmd_tag_i  in  TagWidth  line tag
cmd_idx_i  in  IdxWidth  line index
cmd_off_i  in  OffWidth  requested byte offset
beat_valid_i  in  1  return beat valid
beat_ready_o  out  1  return beat accepted
beat_data_i  in  BeatWidth  return beat data
done_o  out  1  one-cycle pulse concurrent with the refill write
wr_cl_vld_o  out  1  cache-line write strobe to the memory array
wr_cl_nc_o  out  1  noncacheable forward
wr_cl_we_o  out  SetAssoc  way write enables
wr_cl_tag_o  out  TagWidth  tag to write
wr_cl_idx_o  out  IdxWidth  index to write
wr_cl_off_o  out  OffWidth  offset for readout forwarding
wr_cl_data_o  out  LineWidth  assembled line
wr_cl_data_be_o  out  LineWidth/8  byte enables
wr_vld_bits_o  out  SetAssoc  valid bits to store

Behaviour:
- Let NB = LineWidth/BeatWidth.
- Reset: state IDLE, beat counter 0, flush index 0, line buffer 0.
- Reset value of every output is 0, except cmd_ready_o = 1 (IDLE).
- The memory array always accepts wr_cl_vld_o in the cycle it is asserted. No backpressure on the write port.
- States:
  - IDLE: cmd_ready_o=1, beat_ready_o=0.
    - flush_i=1 -> FLUSH. Flush wins over a simultaneous cmd_valid_i, so cmd_ready_o=0 that cycle.
    - cmd_valid_i=1 -> latch cmd fields, counter=0 -> COLLECT.
  - COLLECT: beat_ready_o=1, cmd_ready_o=0.
    - Each accepted beat is written to buffer bits [cnt*BeatWidth +: BeatWidth] and cnt increments.
    - Beats arrive in ascending address order starting at line offset 0.
    - nc: transition to WRITE after 1 beat.
    - Otherwise: transition to WRITE when the beat at cnt = NB-1 is accepted.
    - Gaps in beat_valid_i are allowed with no timeout.
  - WRITE (exactly 1 cycle): wr_cl_vld_o=1, done_o=1, wr_cl_tag/idx/off = latched values, wr_cl_data_o = buffer.
    - Cacheable: wr_cl_we_o = latched way, wr_vld_bits_o = latched way, data_be all ones, nc=0.
    - nc: wr_cl_nc_o=1, we=0, vld_bits=0, be=0. Only forwards data; beat 0 sits in data[BeatWidth-1:0].
    - -> IDLE.
  - FLUSH: per cycle wr_cl_vld_o=1, we=all ones, vld_bits=0, idx=flush index, tag=0, be=0.
    - Index increments each cycle.
    - At index 2**IdxWidth-1: pulse flush_ack_o, index wraps to 0, -> IDLE.
    - Sweep length is exactly 2**IdxWidth cycles and is not interruptible.
- flush_i asserted during COLLECT is held off until return to IDLE. The refill completes first.
- Beats presented while not in COLLECT are not accepted (beat_ready_o=0).
- Line buffer is cleared on each command accept.
- Reset mid-operation: all state returns to IDLE immediately and the partial line is discarded. No write is issued.
- Assertions:
  - cmd_way_i is onehot when a cacheable cmd is accepted.
  - wr_cl_vld_o is never asserted in IDLE or COLLECT.

Test Plan:
1. Cacheable refill: cmd idx=0x12, tag=0xABC, way=0x04; beats 0x1111..., 0x2222... back-to-back -> one cycle later wr_cl_vld_o=1, we=0x04, vld_bits=0x04, data={0x2222...,0x1111...}, be all ones, done_o=1; then cmd_ready_o=1.
2. Noncacheable: cmd nc=1, off=0x8; single beat 0xDEAD -> next cycle wr_cl_vld_o=1, nc=1, we=0, data[63:0]=0xDEAD, off=0x8; a second beat is not accepted.
3. Beat gaps: beat_valid_i toggles 1,0,0,1 -> write issued only after the 2nd accepted beat; data order preserved.
4. Flush from IDLE -> 256 consecutive wr_cl_vld_o cycles, idx 0..255, we=0xFF, vld_bits=0; flush_ack_o pulses with idx=255; then IDLE.
5. flush_i and cmd_valid_i in the same IDLE cycle -> cmd not accepted; flush sweep runs; cmd accepted in the first IDLE cycle after flush_ack_o.
6. rst_ni low after 1 of 2 beats -> no write issued; all outputs 0 except cmd_ready_o=1; a new refill afterwards assembles correctly with a clean buffer.
